costas_loop_filter: RTL and testbench
=====================================

Name: costas_loop_filter

Overview:
- Second-order (proportional-integral) loop filter for the carrier-recovery Costas loop in the DSSS demodulator.
- Consumes the 23-bit signed phase-detector error (sign(yi)·yq). Averages it over DUMP_LEN samples (integrate-and-dump).
- Produces a saturated signed frequency-offset word that the downstream NCO adds to its nominal phase increment.
- Loop gains are powers of two (arithmetic shifts); no multipliers.

Parameters:
- PD_W, 23, phase-error input width (signed).
- DF_W, 32, frequency-word output width (signed); DF_W >= PD_W.
- LOG2_DUMP, 3, log2 of integrate-and-dump length; DUMP_LEN = 2^LOG2_DUMP.
- KP_SHIFT, 4, proportional gain C1 = 2^-KP_SHIFT.
- KI_SHIFT, 10, integral gain C2 = 2^-KI_SHIFT.

Ports:
- clk  in  1  FPGA system clock, 8 MHz.
- rst  in  1  asynchronous reset, active-low (low = reset).
- pd_vld  in  1  phase-error sample strobe; a sample is accepted only when this is high.
- pd  in  PD_W  signed phase-detector error.
- hold  in  1  freeze the integrator (integral increment forced to 0).
- clr  in  1  synchronous clear of the dump accumulator, sample counter, integrator and df.
- df  out  DF_W  signed frequency-offset word to the NCO.
- df_vld  out  1  one-cycle pulse when df updates.
- sat  out  1  one-cycle pulse, coincident with df_vld, if the integrator or df clipped on that update.

Behaviour:
- Reset (rst low, asynchronous): every register goes to 0, i.e. acc, cnt, avg, avg_vld, integ, df, df_vld, sat. A reset mid-dump discards the partial sum; the next dump needs DUMP_LEN fresh samples.
- Stage 1, accumulate:
  - acc has width PD_W+LOG2_DUMP.
  - When pd_vld=1 and cnt<DUMP_LEN-1: acc += pd and cnt++.
  - When pd_vld=1 and cnt==DUMP_LEN-1: avg <= (acc+pd)>>>LOG2_DUMP (arithmetic shift, truncation toward -inf), avg_vld <= 1, acc <= 0, cnt <= 0.
  - When pd_vld=0: acc and cnt hold. Gaps between samples are allowed.
- Stage 2, PI update, on avg_vld:
  - Sign-extend avg to DF_W+1.
  - prop = avg>>>KP_SHIFT.
  - incr = hold ? 0 : avg>>>KI_SHIFT.
  - integ <= SAT(integ+incr).
  - df <= SAT(prop + SAT(integ+incr)).
  - df_vld <= 1; sat <= (either SAT clipped).
- SAT clamps to the range [-2^(DF_W-1), 2^(DF_W-1)-1].
- Latency: the DUMP_LEN-th sample is accepted on rising edge N. df and df_vld are valid after edge N+2. df_vld is high for exactly one cycle; df holds its value between updates.
- clr=1:
  - Clears acc, cnt, avg_vld, integ and df to 0 on the next edge; a pending avg_vld is discarded.
  - Overrides a simultaneous pd_vld (sample dropped) and hold.
  - df_vld and sat are 0 in the cycle after clr.
- hold does not affect stage 1 or the proportional path.
- Throughput: at most one df update per DUMP_LEN accepted samples. pd_vld may be high every cycle with no stall.

Decomposition:
- Shared package (dsss_pkg):
  - PD_W, DF_W defaults.
  - A SAT function of the form sat_add(a, b, width).
  - Loop-gain constants for the acquisition and tracking profiles.
- One sub-module is natural: int_dump (stage 1, parameterised PD_W/LOG2_DUMP, outputs avg/avg_vld). It is reusable by the code-tracking DLL filter.
- The PI stage stays in the top module.

Test Plan (defaults unless stated):
1. pd=1024, pd_vld=1 for 8 cycles from reset → df_vld pulses 2 cycles after the 8th sample; df=65 (prop 64 + integ 1), sat=0.
2. pd=1024 for 80 samples (10 dumps) → final df=74, integ=10. Then pd=-1024 for 8 samples → df=-64+9=-55.
3. pd_vld toggled 1-0-1-0 with pd=1024 → still 8 accepted samples per df_vld (one pulse per 16 cycles); df values match scenario 2.
4. DF_W=24, KI_SHIFT=0, pd=4194303 constant → dump1 df=4456446, sat=0; dump2 df=8388607, sat=1; dump3 integ=8388607, df=8388607, sat=1.
5. Integrator at 10, hold=1, pd=1024 for one dump → integ stays 10, df=74. Then clr pulse in the same cycle as a pd_vld → df=0 and the next dump needs 8 new samples.
6. rst driven low after 5 samples of a dump → df=0, df_vld=0 immediately (asynchronously). After release, 8 samples of pd=1024 → df=65.

Source files
------------

// File: rtl/dsss_pkg.sv
// Shared DSSS demodulator definitions: default widths, loop-gain profiles, saturating add.
// Latency: n/a (package only).
// Backpressure: n/a.
package dsss_pkg;

    localparam int PD_W_DEF = 23;
    localparam int DF_W_DEF = 32;

    // Loop-gain shift profiles (gain = 2^-shift)
    localparam int KP_ACQ = 2;
    localparam int KI_ACQ = 6;
    localparam int KP_TRK = 4;
    localparam int KI_TRK = 10;

    typedef struct packed {
        logic signed [63:0] val;
        logic               clip;
    } sat_t;

    // Adds two sign-extended operands and clamps the result to a signed width-bit range.
    // Callers must keep width <= 63.
    function automatic sat_t sat_add(input logic signed [63:0] a,
                                     input logic signed [63:0] b,
                                     input int width);
        logic signed [64:0] s;
        logic signed [64:0] hi;
        logic signed [64:0] lo;
        sat_t r;
        s  = 65'(a) + 65'(b);
        hi = (65'sd1 <<< (width - 1)) - 65'sd1;
        lo = -(65'sd1 <<< (width - 1));
        r.clip = 1'b0;
        r.val  = 64'(s);
        if (s > hi) begin
            r.val  = 64'(hi);
            r.clip = 1'b1;
        end else if (s < lo) begin
            r.val  = 64'(lo);
            r.clip = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/int_dump.sv
// Integrate-and-dump averager over 2^LOG2_DUMP accepted samples.
// Latency: avg/avg_vld one edge after the registered last sample (two edges after pd_vld).
// Backpressure: none; accepts a sample every cycle, gaps allowed.
module int_dump #(
    parameter int PD_W      = 23,
    parameter int LOG2_DUMP = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   pd_vld,
    input  logic signed [PD_W-1:0] pd,
    output logic signed [PD_W-1:0] avg,
    output logic                   avg_vld
);

    localparam int ACC_W = PD_W + LOG2_DUMP;

    logic                    samp_vld;
    logic signed [PD_W-1:0]  samp;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic [LOG2_DUMP-1:0]    cnt;

    assign sum = acc + ACC_W'(samp);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samp_vld <= 1'b0;
            samp     <= '0;
            acc      <= '0;
            cnt      <= '0;
            avg      <= '0;
            avg_vld  <= 1'b0;
        end else begin
            // clr drops both the sample arriving now and the one already registered
            samp_vld <= pd_vld & ~clr;
            samp     <= pd;
            avg_vld  <= 1'b0;
            if (clr) begin
                acc <= '0;
                cnt <= '0;
            end else if (samp_vld) begin
                if (&cnt) begin
                    avg     <= PD_W'(sum >>> LOG2_DUMP);
                    avg_vld <= 1'b1;
                    acc     <= '0;
                    cnt     <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/costas_loop_filter.sv
// Costas-loop PI filter: averaged phase error -> saturated NCO frequency offset.
// Latency: df/df_vld valid two edges after the edge accepting the last sample of a dump.
// Backpressure: none; pd_vld may be high every cycle.
module costas_loop_filter
    import dsss_pkg::*;
#(
    parameter int PD_W      = PD_W_DEF,
    parameter int DF_W      = DF_W_DEF,
    parameter int LOG2_DUMP = 3,
    parameter int KP_SHIFT  = KP_TRK,
    parameter int KI_SHIFT  = KI_TRK
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pd_vld,
    input  logic signed [PD_W-1:0] pd,
    input  logic                   hold,
    input  logic                   clr,
    output logic signed [DF_W-1:0] df,
    output logic                   df_vld,
    output logic                   sat
);

    logic signed [PD_W-1:0] avg;
    logic                   avg_vld;
    logic signed [DF_W-1:0] integ;

    logic signed [63:0] avg_ext;
    logic signed [63:0] prop;
    logic signed [63:0] incr;
    logic signed [63:0] integ_ext;
    sat_t               s_int;
    sat_t               s_df;

    int_dump #(
        .PD_W      (PD_W),
        .LOG2_DUMP (LOG2_DUMP)
    ) u_int_dump (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .pd_vld  (pd_vld),
        .pd      (pd),
        .avg     (avg),
        .avg_vld (avg_vld)
    );

    always_comb begin
        avg_ext   = 64'(avg);
        integ_ext = 64'(integ);
        prop      = avg_ext >>> KP_SHIFT;
        incr      = hold ? 64'sd0 : (avg_ext >>> KI_SHIFT);
        s_int     = sat_add(integ_ext, incr, DF_W);
        s_df      = sat_add(prop, s_int.val, DF_W);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            integ  <= '0;
            df     <= '0;
            df_vld <= 1'b0;
            sat    <= 1'b0;
        end else begin
            df_vld <= 1'b0;
            sat    <= 1'b0;
            // clr also swallows an average that lands in the same cycle
            if (clr) begin
                integ <= '0;
                df    <= '0;
            end else if (avg_vld) begin
                integ  <= DF_W'(s_int.val);
                df     <= DF_W'(s_df.val);
                df_vld <= 1'b1;
                sat    <= s_int.clip | s_df.clip;
            end
        end
    end

endmodule

// File: tb/tb_costas_loop_filter.sv
// Directed table-driven bench for costas_loop_filter, plus clr and async-reset sequences.
module tb_costas_loop_filter;

    localparam int PD_W = 23;
    localparam int DF_W = 32;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   pd_vld = 1'b0;
    logic signed [PD_W-1:0] pd = '0;
    logic signed [PD_W-1:0] pd2 = 23'sd4194303;
    logic                   hold = 1'b0;
    logic                   clr = 1'b0;
    logic                   hold2 = 1'b0;
    logic                   clr2 = 1'b0;
    logic signed [DF_W-1:0] df;
    logic                   df_vld;
    logic                   sat;
    logic signed [23:0]     df2;
    logic                   df_vld2;
    logic                   sat2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    costas_loop_filter dut (
        .clk(clk), .rst(rst), .pd_vld(pd_vld), .pd(pd), .hold(hold), .clr(clr),
        .df(df), .df_vld(df_vld), .sat(sat)
    );

    costas_loop_filter #(.DF_W(24), .KI_SHIFT(0)) dut2 (
        .clk(clk), .rst(rst), .pd_vld(pd_vld), .pd(pd2), .hold(hold2), .clr(clr2),
        .df(df2), .df_vld(df_vld2), .sat(sat2)
    );

    typedef struct {
        logic signed [PD_W-1:0] v;
        int                     gap;
        logic                   hold;
        logic signed [63:0]     exp_df;
        logic                   chk2;
        logic signed [63:0]     exp_df2;
        logic                   exp_sat2;
    } row_t;

    row_t rows[14];

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Each sample: optional idle cycles, then one cycle with pd_vld high.
    task automatic feed(input int n, input logic signed [PD_W-1:0] v, input int gap);
        for (int i = 0; i < n; i++) begin
            pd_vld = 1'b0;
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
            end
            pd_vld = 1'b1;
            pd     = v;
            @(posedge clk); #1;
        end
        pd_vld = 1'b0;
    endtask

    // Counts negedges after the last accepting edge until df_vld, bounded.
    task automatic wait_df(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!df_vld && lat < 30);
    endtask

    task automatic dump(input string name, input logic signed [PD_W-1:0] v, input int gap,
                        input logic signed [63:0] exp_df);
        int lat;
        feed(8, v, gap);
        wait_df(lat);
        check({name, " latency"}, lat, 3);
        check({name, " df"}, df, exp_df);
        check({name, " sat"}, sat, 0);
        @(negedge clk);
        check({name, " df_vld width"}, df_vld, 0);
        check({name, " df held"}, df, exp_df);
    endtask

    initial begin
        int seen;
        int lat;

        for (int i = 0; i < 10; i++)
            rows[i] = '{v: 23'sd1024, gap: 0, hold: 1'b0, exp_df: 65 + i,
                        chk2: 1'b0, exp_df2: 0, exp_sat2: 1'b0};
        rows[0].chk2 = 1'b1; rows[0].exp_df2 = 4456446; rows[0].exp_sat2 = 1'b0;
        rows[1].chk2 = 1'b1; rows[1].exp_df2 = 8388607; rows[1].exp_sat2 = 1'b1;
        rows[2].chk2 = 1'b1; rows[2].exp_df2 = 8388607; rows[2].exp_sat2 = 1'b1;
        rows[10] = '{v: 23'sd1024,  gap: 0, hold: 1'b1, exp_df: 74,  chk2: 1'b0, exp_df2: 0, exp_sat2: 1'b0};
        rows[11] = '{v: -23'sd1024, gap: 0, hold: 1'b0, exp_df: -55, chk2: 1'b0, exp_df2: 0, exp_sat2: 1'b0};
        rows[12] = '{v: 23'sd1024,  gap: 1, hold: 1'b0, exp_df: 74,  chk2: 1'b0, exp_df2: 0, exp_sat2: 1'b0};
        rows[13] = '{v: 23'sd1024,  gap: 1, hold: 1'b0, exp_df: 75,  chk2: 1'b0, exp_df2: 0, exp_sat2: 1'b0};

        repeat (3) @(negedge clk);
        check("reset df", df, 0);
        check("reset df_vld", df_vld, 0);
        check("reset sat", sat, 0);
        check("reset df2", df2, 0);
        rst = 1'b1;

        for (int r = 0; r < 14; r++) begin
            hold = rows[r].hold;
            feed(8, rows[r].v, rows[r].gap);
            wait_df(lat);
            check($sformatf("row%0d latency", r), lat, 3);
            check($sformatf("row%0d df", r), df, rows[r].exp_df);
            check($sformatf("row%0d sat", r), sat, 0);
            if (rows[r].chk2) begin
                check($sformatf("row%0d df_vld2", r), df_vld2, 1);
                check($sformatf("row%0d df2", r), df2, rows[r].exp_df2);
                check($sformatf("row%0d sat2", r), sat2, rows[r].exp_sat2);
            end
            @(negedge clk);
            check($sformatf("row%0d df_vld width", r), df_vld, 0);
            check($sformatf("row%0d df held", r), df, rows[r].exp_df);
            hold = 1'b0;
        end

        // clr together with a sample: partial dump and the sample are both dropped
        feed(3, 23'sd1024, 0);
        pd_vld = 1'b1;
        clr    = 1'b1;
        @(posedge clk); #1;
        clr    = 1'b0;
        pd_vld = 1'b0;
        @(negedge clk);
        check("clr df", df, 0);
        check("clr df_vld", df_vld, 0);
        check("clr sat", sat, 0);
        feed(7, 23'sd1024, 0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (df_vld) seen++;
        end
        check("clr early df_vld", seen, 0);
        feed(1, 23'sd1024, 0);
        wait_df(lat);
        check("clr refill latency", lat, 3);
        check("clr refill df", df, 65);
        @(negedge clk);

        // asynchronous reset in the middle of a dump
        feed(5, 23'sd1024, 0);
        #2 rst = 1'b0;
        #1;
        check("async rst df", df, 0);
        check("async rst df_vld", df_vld, 0);
        check("async rst sat", sat, 0);
        @(negedge clk);
        rst = 1'b1;
        dump("post-reset", 23'sd1024, 0, 65);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
